// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg: shared types for the I2C command sequencer.
//   i2c_cmd_t   - one queued command {rd, addr, data}
//   seq_state_t - sequencer FSM states
package i2c_seq_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef struct packed {
        logic                  rd;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] data;
    } i2c_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } seq_state_t;
endpackage

// File: rtl/i2c_cmd_fifo.sv
// i2c_cmd_fifo: registered command FIFO, no write-to-read bypass.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and payload (ignored when full)
//   pop, dout     read request (ignored when empty) and current head
//   full, empty   occupancy flags
//   level         number of stored entries, 0..DEPTH
module i2c_cmd_fifo
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  i2c_cmd_t               din,
    input  logic                   pop,
    output i2c_cmd_t               dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    i2c_cmd_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues single-byte I2C commands and issues them one at a
// time to the bus controller, waiting for done, respecting ctl_busy before an
// issue and forcing GAP_CYCLES idle cycles between transactions.
// Optional feature macro: I2C_SEQ_TIMEOUT_EN -- aborts a transaction that sees
// no ctl_done within TIMEOUT_CYCLES cycles and pulses err_timeout.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready = FIFO not full)
//   cmd_rd, cmd_addr, cmd_data       command payload
//   ctl_busy                         bus occupied, blocks a new issue
//   ctl_write_en / ctl_read_en       transaction enables, held until done
//   ctl_addr, ctl_data               transaction payload, stable while enabled
//   ctl_done                         controller completion pulse
//   fifo_level                       queued commands (not counting in-flight)
//   seq_idle                         FIFO empty and FSM idle
//   err_timeout                      one-cycle abort pulse
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rd,
    input  logic [I2C_ADDR_W-1:0]  cmd_addr,
    input  logic [I2C_DATA_W-1:0]  cmd_data,
    input  logic                   ctl_busy,
    output logic                   ctl_write_en,
    output logic                   ctl_read_en,
    output logic [I2C_ADDR_W-1:0]  ctl_addr,
    output logic [I2C_DATA_W-1:0]  ctl_data,
    input  logic                   ctl_done,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   seq_idle,
    output logic                   err_timeout
);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    // A zero or negative timeout has no meaning; no hardware is generated
    // for it, so an illegal value simply leaves this block empty.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_illegal
    end

    seq_state_t            state, state_d;
    logic                  wr_d, rd_d, err_d;
    logic [I2C_ADDR_W-1:0] addr_d;
    logic [I2C_DATA_W-1:0] data_d;
    logic [GW-1:0]         gap_cnt, gap_d;
    logic                  pop, full, empty;
    i2c_cmd_t              head, din;

    assign din       = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};
    assign cmd_ready = !full;
    assign seq_idle  = empty && (state == IDLE);

    i2c_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .din   (din),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt, to_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ctl_write_en <= 1'b0;
            ctl_read_en  <= 1'b0;
            ctl_addr     <= '0;
            ctl_data     <= '0;
            gap_cnt      <= '0;
            err_timeout  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt       <= '0;
`endif
        end else begin
            state        <= state_d;
            ctl_write_en <= wr_d;
            ctl_read_en  <= rd_d;
            ctl_addr     <= addr_d;
            ctl_data     <= data_d;
            gap_cnt      <= gap_d;
            err_timeout  <= err_d;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt       <= to_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        wr_d    = ctl_write_en;
        rd_d    = ctl_read_en;
        addr_d  = ctl_addr;
        data_d  = ctl_data;
        gap_d   = gap_cnt;
        err_d   = 1'b0;
        pop     = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        to_d    = to_cnt;
`endif
        case (state)
            IDLE: begin
                if (!empty && !ctl_busy) begin
                    pop     = 1'b1;
                    wr_d    = !head.rd;
                    rd_d    = head.rd;
                    addr_d  = head.addr;
                    data_d  = head.data;
                    state_d = WAIT_DONE;
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            WAIT_DONE: begin
                // Done takes priority over a coincident timeout expiry.
                if (ctl_done) begin
                    wr_d = 1'b0;
                    rd_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_CYCLES);
                    end
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    wr_d  = 1'b0;
                    rd_d  = 1'b0;
                    err_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                        gap_d   = GW'(GAP_CYCLES);
                    end
                end else begin
                    to_d = to_cnt + 1'b1;
                end
`endif
            end
            GAP: begin
                // Last gap cycle moves to IDLE, so the next issue lands
                // GAP_CYCLES+1 edges after the done edge.
                if (gap_cnt <= GW'(1)) state_d = IDLE;
                else                   gap_d   = gap_cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;
    import i2c_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_rd = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       ctl_busy = 1'b0;
    logic       ctl_write_en, ctl_read_en;
    logic [6:0] ctl_addr;
    logic [7:0] ctl_data;
    logic       ctl_done = 1'b0;
    logic [2:0] fifo_level;
    logic       seq_idle, err_timeout;

    i2c_cmd_sequencer #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .ctl_busy(ctl_busy), .ctl_write_en(ctl_write_en), .ctl_read_en(ctl_read_en),
        .ctl_addr(ctl_addr), .ctl_data(ctl_data), .ctl_done(ctl_done),
        .fifo_level(fifo_level), .seq_idle(seq_idle), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int       npass = 0;
    int       ntot  = 0;
    i2c_cmd_t sb[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic push(input logic rd, input logic [6:0] a, input logic [7:0] d, output logic took);
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        cmd_addr  = a;
        cmd_data  = d;
        took      = cmd_ready;
        if (took) sb.push_back('{rd: rd, addr: a, data: d});
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_issue(input int budget, output int n);
        n = 0;
        while (!(ctl_write_en || ctl_read_en) && n < budget) begin
            tick();
            n++;
        end
        chk("issue_seen", 32'(ctl_write_en || ctl_read_en), 1);
    endtask

    task automatic check_issue(input string tag);
        i2c_cmd_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_wr_en"}, 32'(ctl_write_en), 32'(!e.rd));
            chk({tag, "_rd_en"}, 32'(ctl_read_en), 32'(e.rd));
            chk({tag, "_addr"}, 32'(ctl_addr), 32'(e.addr));
            chk({tag, "_data"}, 32'(ctl_data), 32'(e.data));
        end
    endtask

    task automatic done_pulse();
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        chk("en_drop_on_done", {ctl_write_en, ctl_read_en}, 0);
    endtask

    initial begin
        logic took;
        int   n;
        logic seen, bad_wr, rd_ok;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_seq_idle", 32'(seq_idle), 1);
        chk("rst_enables", {ctl_write_en, ctl_read_en}, 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_err", 32'(err_timeout), 0);
        chk("rst_addr_data", {ctl_addr, ctl_data}, 0);
        rst = 1'b0;
        tick();

        // Stray done while idle is ignored
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        chk("stray_done_idle", 32'(seq_idle), 1);

        // 1: single write, one-edge latency, stable payload, gap to idle
        push(1'b0, 7'h50, 8'hA5, took);
        chk("t1_level_after_push", 32'(fifo_level), 1);
        chk("t1_not_yet_issued", 32'(ctl_write_en), 0);
        tick();
        check_issue("t1");
        repeat (3) tick();
        chk("t1_hold", {ctl_write_en, ctl_addr, ctl_data}, {1'b1, 7'h50, 8'hA5});
        done_pulse();
        chk("t1_gap_not_idle", 32'(seq_idle), 0);
        tick();
        chk("t1_gap_not_idle2", 32'(seq_idle), 0);
        tick();
        chk("t1_idle_after_gap", 32'(seq_idle), 1);

        // 2: read asserts only ctl_read_en
        push(1'b1, 7'h1D, 8'h3C, took);
        tick();
        check_issue("t2");
        bad_wr = 1'b0;
        rd_ok  = 1'b1;
        repeat (5) begin
            tick();
            bad_wr = bad_wr | ctl_write_en;
            rd_ok  = rd_ok & ctl_read_en;
        end
        chk("t2_wr_never", 32'(bad_wr), 0);
        chk("t2_rd_held", 32'(rd_ok), 1);
        done_pulse();
        repeat (2) tick();

        // 3: fill past depth while done is withheld, then drain in order
        for (int i = 0; i < 5; i++) push(1'b0, 7'(8'h10 + i), 8'(8'h80 + i), took);
        chk("t3_level_full", 32'(fifo_level), 4);
        chk("t3_ready_low", 32'(cmd_ready), 0);
        push(1'b1, 7'h7F, 8'hFF, took);
        chk("t3_sixth_rejected", 32'(took), 0);
        chk("t3_level_still_full", 32'(fifo_level), 4);
        check_issue("t3_first");
        for (int k = 0; k < 4; k++) begin
            done_pulse();
            wait_issue(10, n);
            chk("t3_gap_edges", n, 3);
            check_issue("t3_next");
        end
        done_pulse();
        repeat (3) tick();
        chk("t3_drained_idle", 32'(seq_idle), 1);
        chk("t3_sb_empty", sb.size(), 0);

        // 4: busy blocks issue; busy changes during WAIT_DONE ignored
        ctl_busy = 1'b1;
        push(1'b0, 7'h2A, 8'h5A, took);
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | ctl_write_en | ctl_read_en;
        end
        chk("t4_no_issue_busy", 32'(seen), 0);
        ctl_busy = 1'b0;
        tick();
        check_issue("t4");
        ctl_busy = 1'b1;
        repeat (3) tick();
        chk("t4_busy_in_wait", 32'(ctl_write_en), 1);
        ctl_busy = 1'b0;
        done_pulse();
        repeat (2) tick();

        // 5: simultaneous push and pop at level 2, then reset mid-transaction
        push(1'b0, 7'h01, 8'h11, took);
        tick();
        check_issue("t5_a");
        push(1'b0, 7'h02, 8'h22, took);
        push(1'b0, 7'h03, 8'h33, took);
        chk("t5_level2", 32'(fifo_level), 2);
        ctl_done = 1'b1;
        tick();
        ctl_done = 1'b0;
        tick();
        tick();
        push(1'b1, 7'h04, 8'h44, took);
        chk("t5_level_pushpop", 32'(fifo_level), 2);
        check_issue("t5_b");
        rst = 1'b1;
        tick();
        chk("t5_rst_enables", {ctl_write_en, ctl_read_en}, 0);
        chk("t5_rst_level", 32'(fifo_level), 0);
        chk("t5_rst_idle", 32'(seq_idle), 1);
        rst = 1'b0;
        sb.delete();
        tick();

        // 6: timeout behaviour (feature on) or indefinite wait (feature off)
        push(1'b0, 7'h06, 8'h66, took);
        push(1'b1, 7'h07, 8'h77, took);
        check_issue("t6_a");
`ifdef I2C_SEQ_TIMEOUT_EN
        n = 0;
        while (!err_timeout && n < 40) begin
            tick();
            n++;
        end
        chk("t6_timeout_cycle", n, 16);
        chk("t6_en_dropped", {ctl_write_en, ctl_read_en}, 0);
        tick();
        chk("t6_err_one_cycle", 32'(err_timeout), 0);
        wait_issue(10, n);
        chk("t6_gap_after_timeout", n, 2);
        check_issue("t6_b");
`else
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | err_timeout;
        end
        chk("t6_no_err", 32'(seen), 0);
        chk("t6_still_waiting", 32'(ctl_write_en), 1);
        done_pulse();
        wait_issue(10, n);
        chk("t6_gap_edges", n, 3);
        check_issue("t6_b");
`endif
        done_pulse();
        repeat (4) tick();
        chk("final_idle", 32'(seq_idle), 1);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
